// File: rtl/mem_wb.sv
// MEM/WB stage: issues the data-memory access for loads and stores, stalls
// the front of the pipeline while the memory is busy, extracts and extends
// load data, and registers the writeback triple (rd, rwe, data).
module mem_wb (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  sub_op_in,
    input  logic [31:0] daddr_in,
    input  logic [31:0] reg_wdata_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] r_rv2_in,
    input  logic        rwe_in,
    input  logic        is_load_in,
    input  logic        is_store_in,
    input  logic        is_nop_in,
    output logic        dmem_req,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [4:0]  rd_out,
    output logic        rwe_out,
    output logic [31:0] reg_wdata_out,
    output logic [31:0] wb_data_wire,
    output logic        wb_rwe_wire,
    output logic        stall_mem
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // Instruction captured when the access does not complete in its first cycle
    logic [2:0]  r_sub_op;
    logic [31:0] r_daddr;
    logic [4:0]  r_rd;
    logic [31:0] r_rv2;
    logic        r_is_load;
    logic        r_is_store;

    logic [4:0]  r_rd_out;
    logic        r_rwe_out;
    logic [31:0] r_reg_wdata_out;

    logic [2:0]  w_sub_op;
    logic [31:0] w_daddr;
    logic [4:0]  w_rd;
    logic [31:0] w_rv2;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_mem_op;
    logic        w_done;
    logic        w_capture;
    logic [31:0] w_wb_data;
    logic        w_wb_rwe;

    // Byte write enables for a store of the given width at the given lane
    function automatic logic [3:0] store_we(input logic [2:0] op, input logic [1:0] lo);
        logic [3:0] we;
        case (op)
            3'b000:  we = 4'b0001 << lo;
            3'b001:  we = lo[1] ? 4'b1100 : 4'b0011;
            3'b010:  we = 4'b1111;
            default: we = 4'b0000;
        endcase
        return we;
    endfunction

    // Store data replicated across every lane it may land in
    function automatic logic [31:0] store_wdata(input logic [2:0] op, input logic [31:0] rv2);
        logic [31:0] wd;
        case (op)
            3'b000:  wd = {4{rv2[7:0]}};
            3'b001:  wd = {2{rv2[15:0]}};
            default: wd = rv2;
        endcase
        return wd;
    endfunction

    // Select the addressed byte/half of the read word and extend it
    function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] lo,
                                                 input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] d;
        case (lo)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            2'd3:    b = rdata[31:24];
            default: b = 8'h00;
        endcase
        h = lo[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            3'b000:  d = {{24{b[7]}}, b};
            3'b001:  d = {{16{h[15]}}, h};
            3'b010:  d = rdata;
            3'b100:  d = {24'h000000, b};
            3'b101:  d = {16'h0000, h};
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    // Operand source: live inputs in IDLE, captured copy while waiting
    always_comb begin
        w_sub_op   = sub_op_in;
        w_daddr    = daddr_in;
        w_rd       = rd_in;
        w_rv2      = r_rv2_in;
        w_is_load  = is_load_in;
        w_is_store = is_store_in;
        w_mem_op   = 1'b0;
        if (r_state == ST_WAIT) begin
            w_sub_op   = r_sub_op;
            w_daddr    = r_daddr;
            w_rd       = r_rd;
            w_rv2      = r_rv2;
            w_is_load  = r_is_load;
            w_is_store = r_is_store;
            w_mem_op   = 1'b1;
        end else begin
            w_mem_op   = !is_nop_in && (is_load_in || is_store_in);
        end
    end

    assign w_done    = !reset && w_mem_op && dmem_ack;
    assign w_capture = (r_state == ST_IDLE) && w_mem_op && !dmem_ack;

    // Memory port and stall; everything is quiet while reset is held
    always_comb begin
        dmem_req   = !reset && w_mem_op;
        stall_mem  = !reset && w_mem_op && !dmem_ack;
        dmem_addr  = {w_daddr[31:2], 2'b00};
        dmem_wdata = store_wdata(w_sub_op, w_rv2);
        if (!reset && w_mem_op && w_is_store && !w_is_load) begin
            dmem_we = store_we(w_sub_op, w_daddr[1:0]);
        end else begin
            dmem_we = 4'b0000;
        end
    end

    // Writeback selection, also exported for forwarding
    always_comb begin
        w_wb_data = 32'h0000_0000;
        w_wb_rwe  = 1'b0;
        if (w_mem_op) begin
            if (w_done && w_is_load) begin
                w_wb_data = load_extract(w_sub_op, w_daddr[1:0], dmem_rdata);
                w_wb_rwe  = 1'b1;
            end else begin
                w_wb_data = 32'h0000_0000;
                w_wb_rwe  = 1'b0;
            end
        end else if (!is_nop_in) begin
            w_wb_data = reg_wdata_in;
            w_wb_rwe  = rwe_in;
        end else begin
            w_wb_data = 32'h0000_0000;
            w_wb_rwe  = 1'b0;
        end
    end

    assign wb_data_wire = w_wb_data;
    assign wb_rwe_wire  = w_wb_rwe;

    // Next state: wait out an unacknowledged access, leave on ack
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_mem_op && !dmem_ack) begin
                    w_state_next = ST_WAIT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Hold the instruction for the duration of a multi-cycle access
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sub_op   <= 3'b000;
            r_daddr    <= 32'h0000_0000;
            r_rd       <= 5'd0;
            r_rv2      <= 32'h0000_0000;
            r_is_load  <= 1'b0;
            r_is_store <= 1'b0;
        end else if (w_capture) begin
            r_sub_op   <= sub_op_in;
            r_daddr    <= daddr_in;
            r_rd       <= rd_in;
            r_rv2      <= r_rv2_in;
            r_is_load  <= is_load_in;
            r_is_store <= is_store_in;
        end
    end

    // Registered writeback; a stalled cycle becomes a bubble with rd=0
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_out        <= 5'd0;
            r_rwe_out       <= 1'b0;
            r_reg_wdata_out <= 32'h0000_0000;
        end else begin
            r_rd_out        <= w_wb_rwe ? w_rd : 5'd0;
            r_rwe_out       <= w_wb_rwe;
            r_reg_wdata_out <= w_wb_data;
        end
    end

    assign rd_out        = r_rd_out;
    assign rwe_out       = r_rwe_out;
    assign reg_wdata_out = r_reg_wdata_out;

endmodule

// File: tb/tb_mem_wb.sv
// Directed bench for mem_wb: expected writeback triples go into a
// scoreboard queue when an instruction is driven and are compared against
// the registered outputs after the clock edge.
module tb_mem_wb;

    logic        clk;
    logic        reset;
    logic [2:0]  sub_op_in;
    logic [31:0] daddr_in;
    logic [31:0] reg_wdata_in;
    logic [4:0]  rd_in;
    logic [31:0] r_rv2_in;
    logic        rwe_in;
    logic        is_load_in;
    logic        is_store_in;
    logic        is_nop_in;
    logic        dmem_req;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic [4:0]  rd_out;
    logic        rwe_out;
    logic [31:0] reg_wdata_out;
    logic [31:0] wb_data_wire;
    logic        wb_rwe_wire;
    logic        stall_mem;

    typedef struct {
        logic [4:0]  rd;
        logic        rwe;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    mem_wb dut (
        .clk           (clk),
        .reset         (reset),
        .sub_op_in     (sub_op_in),
        .daddr_in      (daddr_in),
        .reg_wdata_in  (reg_wdata_in),
        .rd_in         (rd_in),
        .r_rv2_in      (r_rv2_in),
        .rwe_in        (rwe_in),
        .is_load_in    (is_load_in),
        .is_store_in   (is_store_in),
        .is_nop_in     (is_nop_in),
        .dmem_req      (dmem_req),
        .dmem_addr     (dmem_addr),
        .dmem_we       (dmem_we),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack),
        .rd_out        (rd_out),
        .rwe_out       (rwe_out),
        .reg_wdata_out (reg_wdata_out),
        .wb_data_wire  (wb_data_wire),
        .wb_rwe_wire   (wb_rwe_wire),
        .stall_mem     (stall_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Push the expected writeback for this cycle, clock, then pop and compare
    task automatic cyc(input string tag, input logic [4:0] rd, input logic rwe, input logic [31:0] data);
        exp_t e;
        e.rd = rd;
        e.rwe = rwe;
        e.data = data;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".rd_out"}, 32'(rd_out), 32'(e.rd));
        chk({tag, ".rwe_out"}, 32'(rwe_out), 32'(e.rwe));
        chk({tag, ".wdata_out"}, reg_wdata_out, e.data);
    endtask

    task automatic idle();
        sub_op_in = 3'b000; daddr_in = 32'h0; reg_wdata_in = 32'h0; rd_in = 5'd0;
        r_rv2_in = 32'h0; rwe_in = 1'b0; is_load_in = 1'b0; is_store_in = 1'b0;
        is_nop_in = 1'b0; dmem_rdata = 32'h0; dmem_ack = 1'b0;
    endtask

    task automatic comb(input string tag, input logic req, input logic stall);
        #2;
        chk({tag, ".req"}, 32'(dmem_req), 32'(req));
        chk({tag, ".stall"}, 32'(stall_mem), 32'(stall));
    endtask

    task automatic zw_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [4:0] rd,
                           input logic [31:0] exp_addr, input logic [31:0] exp_data);
        idle();
        is_load_in = 1'b1; sub_op_in = op; daddr_in = addr; dmem_rdata = rdata;
        rd_in = rd; dmem_ack = 1'b1;
        comb(tag, 1'b1, 1'b0);
        chk({tag, ".addr"}, dmem_addr, exp_addr);
        chk({tag, ".we"}, 32'(dmem_we), 32'h0);
        cyc(tag, rd, 1'b1, exp_data);
        idle();
    endtask

    task automatic zw_store(input string tag, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] rv2, input logic [31:0] exp_addr,
                            input logic [3:0] exp_we, input logic [31:0] exp_wdata);
        idle();
        is_store_in = 1'b1; sub_op_in = op; daddr_in = addr; r_rv2_in = rv2;
        rd_in = 5'd6; rwe_in = 1'b1; dmem_ack = 1'b1;
        comb(tag, 1'b1, 1'b0);
        chk({tag, ".addr"}, dmem_addr, exp_addr);
        chk({tag, ".we"}, 32'(dmem_we), 32'(exp_we));
        chk({tag, ".wdata"}, dmem_wdata, exp_wdata);
        cyc(tag, 5'd0, 1'b0, 32'h0);
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        // reset with a store presented: port must stay quiet
        is_store_in = 1'b1; sub_op_in = 3'b010; daddr_in = 32'h10; r_rv2_in = 32'h55;
        comb("rst_comb", 1'b0, 1'b0);
        chk("rst_comb.we", 32'(dmem_we), 32'h0);
        cyc("rst", 5'd0, 1'b0, 32'h0);
        idle();
        cyc("rst2", 5'd0, 1'b0, 32'h0);
        reset = 1'b0;

        // ALU pass-through
        rwe_in = 1'b1; rd_in = 5'd5; reg_wdata_in = 32'h0000_1234;
        comb("alu", 1'b0, 1'b0);
        chk("alu.fwd_data", wb_data_wire, 32'h0000_1234);
        chk("alu.fwd_rwe", 32'(wb_rwe_wire), 32'h1);
        cyc("alu", 5'd5, 1'b1, 32'h0000_1234);
        idle();

        // zero-wait loads
        zw_load("lb",   3'b000, 32'h103, 32'h80AA_BBCC, 5'd7,  32'h100, 32'hFFFF_FF80);
        chk("lb.after_stall", 32'(stall_mem), 32'h0);
        zw_load("lh",   3'b001, 32'h002, 32'h8001_0000, 5'd1,  32'h000, 32'hFFFF_8001);
        zw_load("lbu",  3'b100, 32'h001, 32'h0000_F500, 5'd2,  32'h000, 32'h0000_00F5);
        zw_load("lw",   3'b010, 32'h007, 32'hDEAD_BEEF, 5'd31, 32'h004, 32'hDEAD_BEEF);
        zw_load("lbad", 3'b011, 32'h008, 32'hFFFF_FFFF, 5'd3,  32'h008, 32'h0000_0000);

        // zero-wait stores
        zw_store("sb", 3'b000, 32'h011, 32'h1234_56A5, 32'h010, 4'b0010, 32'hA5A5_A5A5);
        zw_store("sh", 3'b001, 32'h031, 32'h0000_1357, 32'h030, 4'b0011, 32'h1357_1357);
        zw_store("sw", 3'b010, 32'h023, 32'hCAFE_F00D, 32'h020, 4'b1111, 32'hCAFE_F00D);

        // multi-cycle SH: three stalled cycles, inputs changed after the first
        is_store_in = 1'b1; sub_op_in = 3'b001; daddr_in = 32'h202; r_rv2_in = 32'h0000_BEEF;
        rd_in = 5'd9; rwe_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_ack = 1'b1;
            comb($sformatf("sh_mc%0d", i), 1'b1, (i < 3) ? 1'b1 : 1'b0);
            chk($sformatf("sh_mc%0d.addr", i), dmem_addr, 32'h200);
            chk($sformatf("sh_mc%0d.we", i), 32'(dmem_we), 32'hC);
            chk($sformatf("sh_mc%0d.wdata", i), dmem_wdata, 32'hBEEF_BEEF);
            cyc($sformatf("sh_mc%0d", i), 5'd0, 1'b0, 32'h0);
            if (i == 0) begin
                sub_op_in = 3'b010; daddr_in = 32'h555; r_rv2_in = 32'h1234_5678;
                is_store_in = 1'b0; is_load_in = 1'b1; is_nop_in = 1'b1; rd_in = 5'd17;
            end
        end
        idle();
        comb("sh_mc_done", 1'b0, 1'b0);
        cyc("sh_mc_done", 5'd0, 1'b0, 32'h0);

        // multi-cycle LHU: two stalled cycles then ack
        is_load_in = 1'b1; sub_op_in = 3'b101; daddr_in = 32'h40; dmem_rdata = 32'h1234_F00D;
        rd_in = 5'd12;
        comb("lhu_w0", 1'b1, 1'b1);
        cyc("lhu_w0", 5'd0, 1'b0, 32'h0);
        comb("lhu_w1", 1'b1, 1'b1);
        cyc("lhu_w1", 5'd0, 1'b0, 32'h0);
        dmem_ack = 1'b1;
        comb("lhu_ack", 1'b1, 1'b0);
        chk("lhu_ack.fwd_data", wb_data_wire, 32'h0000_F00D);
        cyc("lhu_ack", 5'd12, 1'b1, 32'h0000_F00D);
        idle();

        // reset while a load is pending, then a late ack
        is_load_in = 1'b1; sub_op_in = 3'b010; daddr_in = 32'h80; rd_in = 5'd3;
        dmem_rdata = 32'h0BAD_0BAD;
        comb("rw_pend", 1'b1, 1'b1);
        cyc("rw_pend", 5'd0, 1'b0, 32'h0);
        idle();
        reset = 1'b1;
        comb("rw_rst", 1'b0, 1'b0);
        chk("rw_rst.we", 32'(dmem_we), 32'h0);
        cyc("rw_rst", 5'd0, 1'b0, 32'h0);
        reset = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_0BAD;
        comb("rw_late", 1'b0, 1'b0);
        chk("rw_late.fwd_rwe", 32'(wb_rwe_wire), 32'h0);
        cyc("rw_late", 5'd0, 1'b0, 32'h0);
        dmem_ack = 1'b0;
        comb("rw_idle", 1'b0, 1'b0);
        cyc("rw_idle", 5'd0, 1'b0, 32'h0);

        // nop carrying a load flag
        is_nop_in = 1'b1; is_load_in = 1'b1; rd_in = 5'd4; rwe_in = 1'b1;
        reg_wdata_in = 32'h1111_2222; daddr_in = 32'h44;
        comb("nop", 1'b0, 1'b0);
        cyc("nop", 5'd0, 1'b0, 32'h0);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
